uart_tx_fifo: RTL and testbench

- Byte buffer and drain sequencer directly upstream of the UART transmitter.
- The CPU/bus side pushes bytes at full clock rate.
- The block holds them in a FIFO and hands them one at a time to the transmitter.
- It uses the transmitter's tx_start / tx_ready handshake and never issues a second start while a frame is in flight.

---
 rtl/uart_tx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: buffers bus writes and drains them one frame at a
// time through the tx_start / tx_ready handshake.
module uart_tx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [7:0]            tx_data,
  output logic                  tx_start,
  input  logic                  tx_ready
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  logic [7:0]            mem [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_start_q, tx_start_d;
  state_e                state_q, state_d;
  logic                  wr_accept, wr_drop, pop;

  assign full     = (count_q == DepthCnt);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

  // Flush swallows both the same-cycle write and the same-cycle pop.
  assign wr_accept = wr_en && !full && !flush;
  assign wr_drop   = wr_en && full && !flush;
  assign pop       = (state_q == StIdle) && !empty && tx_ready && !flush;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({wr_accept, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // A dropped write beats a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (wr_drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          tx_data_d  = mem[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = StWaitBusy;
        end
      end
      // tx_ready is still high during the pulse cycle; only its fall means the frame started.
      StWaitBusy: begin
        if (!tx_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a per-cycle vector table plus hand-written sequences driven
// by a small transmitter model.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       full, empty, overflow, tx_start;
  logic [4:0] count;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;

  uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transmitter model state: ready falls one cycle after the pulse, returns busy_len cycles later.
  bit         model_on = 1'b0;
  bit         drop_pend = 1'b0;
  bit         prev_start = 1'b0;
  int         busy = 0;
  int         busy_len = 3;
  int         viol = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rdy;
    logic       flush;
    logic       ovf_clr;
    int         e_count;
    logic       e_empty;
    logic       e_full;
    logic       e_ovf;
    logic       e_start;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out (got no event, expected one)", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (model_on) begin
      if (tx_start) begin
        if (!tx_ready || prev_start) viol++;
        got_q.push_back(tx_data);
        drop_pend = 1'b1;
      end else if (drop_pend) begin
        tx_ready  = 1'b0;
        busy      = busy_len;
        drop_pend = 1'b0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) tx_ready = 1'b1;
      end
    end
    prev_start = tx_start;
  endtask

  task automatic wait_model_idle(input string name);
    int n = 0;
    while ((drop_pend || busy != 0) && n < 3000) begin
      cyc();
      n++;
    end
    if (n >= 3000) timeout(name);
    cyc();
    cyc();
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    cyc();
    wr_en   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int idx;

    vecs[0]  = '{1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h41};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[4]  = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h41};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h42};
    vecs[7]  = '{1'b1, 8'h43, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42};
    vecs[8]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42};
    vecs[9]  = '{1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42};
    vecs[10] = '{1'b1, 8'h46, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43};
    vecs[11] = '{1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[16] = '{1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h43};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h50};

    // Reset state
    cyc();
    cyc();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_start", int'(tx_start), 0);
    chk("rst_data", int'(tx_data), 8'h00);
    rst = 1'b0;
    cyc();

    // Cycle-by-cycle table: latency, handshake, simultaneous write/pop, flush
    foreach (vecs[i]) begin
      wr_en    = vecs[i].wr_en;
      wr_data  = vecs[i].wr_data;
      tx_ready = vecs[i].rdy;
      flush    = vecs[i].flush;
      ovf_clr  = vecs[i].ovf_clr;
      cyc();
      chk($sformatf("vec%0d_count", i), int'(count), vecs[i].e_count);
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vecs[i].e_empty));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].e_full));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_start", i), int'(tx_start), int'(vecs[i].e_start));
      chk($sformatf("vec%0d_data", i), int'(tx_data), int'(vecs[i].e_data));
    end
    wr_en = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    tx_ready = 1'b0; cyc();
    tx_ready = 1'b1; cyc(); cyc();

    // Burst of 5 with a slow transmitter
    got_q.delete(); viol = 0; busy_len = 1000; model_on = 1'b1; prev_start = 1'b0;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    n = 0;
    while (got_q.size() < 5 && n < 8000) begin cyc(); n++; end
    if (n >= 8000) timeout("t2_drain");
    wait_model_idle("t2_idle");
    chk("t2_nbytes", got_q.size(), 5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      chk($sformatf("t2_byte%0d", i), int'(got_q[i]), 8'h30 + i);
    chk("t2_viol", viol, 0);
    chk("t2_empty", int'(empty), 1);

    // Fill with drain stalled, overflow, set-wins, clear
    model_on = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'h60 + 8'(i));
    chk("t3_count16", int'(count), 16);
    chk("t3_full", int'(full), 1);
    chk("t3_ovf_pre", int'(overflow), 0);
    push(8'hFF);
    chk("t3_ovf_set", int'(overflow), 1);
    chk("t3_count_hold", int'(count), 16);
    ovf_clr = 1'b1;
    push(8'hFE);
    chk("t3_set_wins", int'(overflow), 1);
    cyc();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", int'(overflow), 0);
    got_q.delete(); viol = 0; busy_len = 3; tx_ready = 1'b1; model_on = 1'b1;
    n = 0;
    while (got_q.size() < 16 && n < 400) begin cyc(); n++; end
    if (n >= 400) timeout("t3_drain");
    for (int i = 0; i < 20; i++) cyc();
    wait_model_idle("t3_idle");
    chk("t3_nbytes", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++)
      chk($sformatf("t3_byte%0d", i), int'(got_q[i]), 8'h60 + i);
    chk("t3_viol", viol, 0);

    // Write+pop at count 5, then stream 40 bytes across pointer wrap
    model_on = 1'b0; tx_ready = 1'b0;
    exp_q.delete(); got_q.delete(); viol = 0;
    for (int i = 0; i < 5; i++) begin
      push(8'h70 + 8'(i));
      exp_q.push_back(8'h70 + 8'(i));
    end
    chk("t4_count5", int'(count), 5);
    tx_ready = 1'b1; model_on = 1'b1; prev_start = 1'b0;
    push(8'hA5);
    exp_q.push_back(8'hA5);
    chk("t4_wrpop_count", int'(count), 5);
    chk("t4_wrpop_start", int'(tx_start), 1);
    idx = 0; n = 0;
    while ((idx < 40 || got_q.size() < exp_q.size()) && n < 1500) begin
      wr_en = (idx < 40) && !full;
      wr_data = 8'h80 + 8'(idx);
      if (wr_en) begin
        exp_q.push_back(wr_data);
        idx++;
      end
      cyc();
      n++;
    end
    wr_en = 1'b0;
    if (n >= 1500) timeout("t4_stream");
    wait_model_idle("t4_idle");
    chk("t4_nbytes", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("t4_byte%0d", i), int'(got_q[i]), int'(exp_q[i]));
    chk("t4_viol", viol, 0);
    chk("t4_ovf", int'(overflow), 0);

    // Flush while byte 0 is in WAIT_DONE
    got_q.delete(); viol = 0; busy_len = 20;
    for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
    n = 0;
    while (tx_ready && n < 20) begin cyc(); n++; end
    if (n >= 20) timeout("t5_busy");
    cyc();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    cyc();
    flush = 1'b0; wr_en = 1'b0;
    chk("t5_count", int'(count), 0);
    chk("t5_empty", int'(empty), 1);
    chk("t5_ovf", int'(overflow), 0);
    for (int i = 0; i < 60; i++) cyc();
    chk("t5_nbytes", got_q.size(), 1);
    if (got_q.size() > 0) chk("t5_byte0", int'(got_q[0]), 8'hC0);
    chk("t5_count_end", int'(count), 0);
    chk("t5_viol", viol, 0);
    wait_model_idle("t5_idle");

    // Reset in WAIT_BUSY with 3 bytes queued
    model_on = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    chk("t6_count4", int'(count), 4);
    tx_ready = 1'b1;
    cyc();
    chk("t6_start", int'(tx_start), 1);
    chk("t6_count3", int'(count), 3);
    rst = 1'b1;
    #2;
    chk("t6_rst_start", int'(tx_start), 0);
    chk("t6_rst_count", int'(count), 0);
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_ovf", int'(overflow), 0);
    chk("t6_rst_data", int'(tx_data), 8'h00);
    cyc();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (tx_start) n++;
    end
    chk("t6_no_pulse", n, 0);
    push(8'h5A);
    cyc();
    chk("t6_new_start", int'(tx_start), 1);
    chk("t6_new_data", int'(tx_data), 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
